// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: data-memory req/ack port between the memory stage (master) and data memory (slave).
interface memory_access_unit_if #(parameter int DATA_WIDTH = 32);
   logic req, we, ack;
   logic [DATA_WIDTH-1:0] addr, wdata, rdata;
   logic [3:0] wstrb;
   modport master(output req, we, addr, wdata, wstrb, input rdata, ack);
   modport slave(input req, we, addr, wdata, wstrb, output rdata, ack);
endinterface

// File: rtl/memory_access_unit.sv
// memory_access_unit: memory stage running req/ack data-memory accesses and stalling upstream until done.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking the low address bits.
module memory_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int REGISTER_ADDRESS_WIDTH = 5,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic resultSRCE_i,
   input  logic memWriteE_i,
   input  logic [DATA_WIDTH-1:0] ALUresultE_i,
   input  logic [DATA_WIDTH-1:0] RD2E_i,
   input  logic [1:0] memTypeE_i,
   input  logic memSignE_i,
   input  logic regWriteE_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3E_i,
   memory_access_unit_if.master mem,
   output logic stall_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic regWriteM_o,
   output logic [REGISTER_ADDRESS_WIDTH-1:0] AD3M_o,
   output logic bus_err_o,
   output logic misalign_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic access, mis, hit, timeout, err, mis_q;
   logic [1:0] a;
   logic [7:0] lb;
   logic [15:0] lh;
   logic [DATA_WIDTH-1:0] ld_fmt, ldata;
   assign access = resultSRCE_i | memWriteE_i;
   assign a = ALUresultE_i[1:0];
   assign hit = state == REQ && mem.ack;
   // ack on the last allowed cycle still wins over the timeout
   assign timeout = state == REQ && !mem.ack && cnt == CW'(TIMEOUT_CYCLES - 1);
`ifdef LSU_MISALIGN_TRAP_EN
   assign mis = access && (memTypeE_i == 2'b01 ? a[0] : memTypeE_i[1] && a != 2'b00);
`else
   assign mis = 1'b0;
`endif
   assign lb = mem.rdata[{a, 3'b000} +: 8];
   assign lh = mem.rdata[{a[1], 4'b0000} +: 16];
   assign ld_fmt = memTypeE_i[1] ? mem.rdata : memTypeE_i[0] ? {{16{memSignE_i & lh[15]}}, lh} : {{24{memSignE_i & lb[7]}}, lb};
   assign mem.req = state == REQ;
   assign AD3M_o = AD3E_i;
   assign bus_err_o = err;
   assign misalign_o = mis_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == IDLE ? (mis ? DONE : access ? REQ : IDLE) : state == REQ ? ((hit || timeout) ? DONE : REQ) : IDLE;
      stall_o = state == REQ || (state == IDLE && access);
      result_o = state == DONE ? ldata : ALUresultE_i;
      regWriteM_o = state == DONE ? regWriteE_i & resultSRCE_i & !memWriteE_i & !err & !mis_q : state == IDLE && !access && regWriteE_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         mem.we <= 1'b0;
         mem.addr <= '0;
         mem.wdata <= '0;
         mem.wstrb <= 4'b0000;
         ldata <= '0;
         err <= 1'b0;
         mis_q <= 1'b0;
      end else begin
         err <= timeout;
         mis_q <= state == IDLE && mis;
         cnt <= state == REQ ? cnt + 1'b1 : '0;
         if (state == IDLE && access && !mis) begin
            mem.addr <= {ALUresultE_i[DATA_WIDTH-1:2], 2'b00};
            mem.we <= memWriteE_i;
            mem.wdata <= memTypeE_i[1] ? RD2E_i : memTypeE_i[0] ? {2{RD2E_i[15:0]}} : {4{RD2E_i[7:0]}};
            mem.wstrb <= memTypeE_i[1] ? 4'b1111 : memTypeE_i[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
         end
         if (hit) ldata <= ld_fmt;
         else if (timeout || (state == IDLE && mis)) ldata <= '0;
      end
   end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: scoreboard bench with a reactive memory slave and a byte-level reference model.
module tb_memory_access_unit;
   localparam int T = 15;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   typedef struct {logic [31:0] res; logic rw, err, mis, cres; logic [4:0] ad3; int stalls;} exp_t;
   typedef struct {logic [31:0] addr, wdata; logic we; logic [3:0] wstrb;} bus_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic ld = 0, st = 0, sg = 0, rw = 0;
   logic [31:0] alu = 0, rd2 = 0;
   logic [1:0] ty = 0;
   logic [4:0] ad3 = 0;
   logic stall, rwm, berr, mis;
   logic [31:0] res;
   logic [4:0] ad3m;
   int total = 0, bad = 0, cur_delay = 0;
   bit busy = 0;
   logic [31:0] cur_rdata = 0;
   exp_t exp_q[$];
   bus_t bus_q[$];
   memory_access_unit_if #(.DATA_WIDTH(32)) mem();
   memory_access_unit #(.DATA_WIDTH(32), .REGISTER_ADDRESS_WIDTH(5), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .resultSRCE_i(ld), .memWriteE_i(st), .ALUresultE_i(alu), .RD2E_i(rd2),
      .memTypeE_i(ty), .memSignE_i(sg), .regWriteE_i(rw), .AD3E_i(ad3), .mem(mem), .stall_o(stall),
      .result_o(res), .regWriteM_o(rwm), .AD3M_o(ad3m), .bus_err_o(berr), .misalign_o(mis));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask
   function automatic logic [31:0] ref_load(logic [31:0] rd, int off, int nb, logic s);
      logic [63:0] v;
      v = (64'(rd) >> (8 * off)) & ((64'd1 << (8 * nb)) - 1);
      if (s && nb < 4 && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
      return v[31:0];
   endfunction
   function automatic logic [31:0] ref_wdata(logic [31:0] d, int nb);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8 * i +: 8] = d[8 * (i % nb) +: 8];
      return w;
   endfunction
   // memory slave: acks after cur_delay REQ cycles, toggles ack randomly while no request is pending
   initial begin
      int n = 0;
      mem.ack = 1'b0;
      mem.rdata = '0;
      forever begin
         @(negedge clk);
         if (mem.req) begin
            mem.ack = n == cur_delay;
            n++;
         end else begin
            mem.ack = 1'($urandom % 2);
            n = 0;
         end
         mem.rdata = (mem.ack && mem.req) ? cur_rdata : $urandom;
      end
   end
   initial begin
      int sc = 0;
      bit preq = 0;
      exp_t e;
      bus_t b = '{default: '0};
      forever begin
         @(negedge clk);
         if (!rst_n || !busy) begin
            sc = 0;
            preq = 0;
         end else begin
            if (mem.req) begin
               if (!preq) begin
                  if (bus_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL bus_unexpected: req=1 with nothing queued, required no request");
                  end else b = bus_q.pop_front();
               end
               chk("bus_addr", mem.addr, b.addr);
               chk("bus_we", 32'(mem.we), 32'(b.we));
               if (b.we) begin
                  chk("bus_wdata", mem.wdata, b.wdata);
                  chk("bus_wstrb", 32'(mem.wstrb), 32'(b.wstrb));
               end
            end
            preq = mem.req;
            if (stall) begin
               sc++;
               chk("err_quiet", 32'(berr), 0);
               chk("mis_quiet", 32'(mis), 0);
            end else if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL result_unexpected: completion with nothing queued");
            end else begin
               e = exp_q.pop_front();
               chk("stall_cycles", 32'(sc), 32'(e.stalls));
               chk("regwrite", 32'(rwm), 32'(e.rw));
               chk("bus_err", 32'(berr), 32'(e.err));
               chk("misalign", 32'(mis), 32'(e.mis));
               chk("ad3", 32'(ad3m), 32'(e.ad3));
               if (e.cres) chk("result", res, e.res);
               sc = 0;
            end
         end
      end
   end
   task automatic issue(input logic l, s, input logic [31:0] a, d, input logic [1:0] t, input logic g, w,
                        input logic [4:0] r, input logic [31:0] rdat, input int dly);
      exp_t e;
      bus_t b;
      int nb, off, n;
      bit m, er;
      @(posedge clk);
      #1;
      ld = l; st = s; alu = a; rd2 = d; ty = t; sg = g; rw = w; ad3 = r;
      cur_rdata = rdat;
      cur_delay = dly;
      nb = t == 0 ? 1 : t == 1 ? 2 : 4;
      off = nb == 4 ? 0 : int'(a % 4) / nb * nb;
      m = TRAP && (l || s) && int'(a % 4) % nb != 0;
      er = (l || s) && !m && dly >= T;
      e.ad3 = r;
      e.mis = m;
      e.err = er;
      if (!(l || s)) begin
         e.res = a; e.rw = w; e.cres = 1; e.stalls = 0;
      end else begin
         e.stalls = m ? 1 : 1 + (er ? T : dly + 1);
         e.rw = l && !s && w && !er && !m;
         e.cres = m || (l && !s);
         e.res = (m || er) ? 32'd0 : ref_load(rdat, off, nb, g);
         if (!m) begin
            b.addr = a & ~32'd3;
            b.we = s;
            b.wdata = ref_wdata(d, nb);
            b.wstrb = 4'(((1 << nb) - 1) << off);
            bus_q.push_back(b);
         end
      end
      exp_q.push_back(e);
      busy = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (stall && n < 40);
      if (stall) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: stall=%0d after %0d cycles, required 0", stall, n);
      end
   endtask
   task automatic idle_bus();
      @(posedge clk);
      #1;
      busy = 0;
      ld = 0;
      st = 0;
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(mem.req), 0);
      chk("rst_we", 32'(mem.we), 0);
      chk("rst_addr", mem.addr, 0);
      chk("rst_wdata", mem.wdata, 0);
      chk("rst_wstrb", 32'(mem.wstrb), 0);
      chk("rst_err", 32'(berr), 0);
      chk("rst_mis", 32'(mis), 0);
      chk("rst_stall", 32'(stall), 0);
      rst_n = 1;
      issue(0, 0, 32'h1234_5678, 0, 2'b10, 0, 1, 5'd1, 0, 0);
      issue(0, 1, 32'h104, 32'hDEADBEEF, 2'b10, 0, 1, 5'd3, 0, 0);
      issue(1, 0, 32'h203, 0, 2'b00, 1, 1, 5'd7, 32'h80FF_1234, 0);
      issue(1, 0, 32'h203, 0, 2'b00, 0, 1, 5'd8, 32'h80FF_1234, 1);
      issue(0, 1, 32'h12, 32'h1234ABCD, 2'b01, 0, 1, 5'd9, 0, 2);
      issue(1, 0, 32'h40, 0, 2'b10, 0, 1, 5'd10, 32'h5555_AAAA, 99);
      issue(1, 0, 32'h44, 0, 2'b01, 1, 1, 5'd11, 32'h8001_7FFF, T - 1);
      issue(1, 0, 32'h48, 0, 2'b10, 0, 1, 5'd12, 32'h1111_2222, T);
      issue(1, 0, 32'h102, 0, 2'b10, 0, 1, 5'd13, 32'hCAFE_F00D, 0);
      issue(1, 0, 32'h203, 0, 2'b01, 1, 1, 5'd14, 32'h9234_5678, 0);
      issue(1, 1, 32'h301, 32'hA5A5_0F0F, 2'b00, 0, 1, 5'd15, 0, 0);
      idle_bus();
      ld = 1; ty = 2'b10; alu = 32'h300; cur_delay = 99;
      n = 0;
      while (!mem.req && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", 32'(mem.req), 1);
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("rst_mid_req", 32'(mem.req), 0);
      chk("rst_mid_addr", mem.addr, 0);
      exp_q.delete();
      bus_q.delete();
      ld = 0;
      @(negedge clk);
      rst_n = 1;
      issue(0, 0, 32'hFEED_0001, 0, 2'b00, 0, 1, 5'd21, 0, 0);
      for (int i = 0; i < 300; i++) begin
         int c, p, dly;
         c = $urandom % 4;
         p = $urandom % 10;
         dly = p < 6 ? p % 4 : p == 6 ? T - 1 : p == 7 ? T : p == 8 ? 99 : int'($urandom % (T - 1));
         issue(c == 1 || c == 3, c >= 2, $urandom, $urandom, 2'($urandom % 4), 1'($urandom % 2),
               1'($urandom % 2), 5'($urandom % 32), $urandom, dly);
      end
      idle_bus();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
